bus_memory_target: RTL and testbench
====================================

Name: bus_memory_target

Overview:
- Memory-side endpoint of the memory bus. Consumes request packets that CPU-side agents post on the bus. Services reads and writes against an internal word array after a programmable access latency.
- Posts read-response packets back on the bus response channel.
- Sits directly downstream of the bus request channel and upstream of the bus response channel.

Parameters:
- DEPTH, 1024, number of payload-wide words in the array; power of two.
- LATENCY, 2, cycles from packet capture to array access; must be >= 1.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  bus request_busy: a request packet is posted
- req_packet  in  $bits(BusPacket)  bus request_data
- req_accept  out  1  one-cycle pulse; the bus clears request_busy on the following edge
- resp_busy  in  1  bus response_busy: response slot occupied
- resp_packet  out  $bits(BusPacket)  response packet; valid while resp_send=1
- resp_send  out  1  one-cycle pulse; the bus latches resp_packet and sets response_busy
- read_count  out  CNT_WIDTH  serviced reads, saturating
- write_count  out  CNT_WIDTH  serviced writes, saturating
- proto_err_count  out  CNT_WIDTH  dropped illegal requests, saturating

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; req_accept, resp_send, resp_packet and all counters are 0.
- Array contents are not reset.
- Reset asserted mid-operation aborts the in-flight request with no write and no response.
- Index: idx = address mod DEPTH, i.e. the low $clog2(DEPTH) bits. Upper address bits are ignored, so addresses wrap.
- State machine IDLE, WAIT, RESPOND:
  - IDLE, req_valid=1 at an edge: capture req_packet. Set cnt=LATENCY-1 and go to WAIT. req_accept=1 for exactly the next cycle.
  - IDLE, packet_type not read/write (e.g. bus_read_response): still capture and accept, so the bus drains. Increment proto_err_count and stay in IDLE. No array access.
  - WAIT, cnt!=0: decrement cnt.
  - WAIT, cnt==0 and request is a write: mem[idx] <= payload, increment write_count, go to IDLE.
  - WAIT, cnt==0 and request is a read: latch resp_packet = {bus_read_response, source of the requester, address 0, mem[idx]}. Increment read_count and go to RESPOND.
  - RESPOND: resp_send = !resp_busy, combinational. On an edge with resp_send=1, go to IDLE. While resp_busy=1, hold resp_packet stable and wait indefinitely.
- Latency, request seen in cycle 0, LATENCY=L:
  - Write is visible to a later read from cycle L+1.
  - resp_send is first high in cycle L+1, later if resp_busy is high.
- Throughput: one request in flight. The next capture is possible in the first IDLE cycle.
  - req_accept always precedes IDLE re-entry by at least one edge, so the same packet is never captured twice.
- Ordering: strictly in order. A read after a write to the same idx returns the new data.
- Counters saturate at all-ones and never wrap.
- Assertions:
  - req_accept never high when req_valid was low at the capture edge.
  - resp_send never high while resp_busy is high.

Decomposition:
- Shared bus package holds: memory_address_t (32b), bus_packet_payload_t (64b), the BusID enum (2b), the packet_type enum {bus_read_data, bus_write_data, bus_read_response} (2b), and the BusPacket packed struct {packet_type, source, address, payload}.
- Sub-module target_word_ram: single-port synchronous RAM (DEPTH x payload width, write enable, read data registered on the access edge).
- FSM and counters stay in bus_memory_target.

Test Plan:
- Write then read, L=2: write addr 0x10, payload 0xDEADBEEF_CAFEF00D, source=1; then read 0x10, source=1.
  - req_accept pulses once per request.
  - resp_send appears 3 cycles after the read is posted.
  - Response is {bus_read_response, source 1, address 0, payload 0xDEADBEEF_CAFEF00D}.
  - read_count=1, write_count=1.
- Wrap-around, DEPTH=1024: write 0x400 with payload 0x5A; read 0x0.
  - Read returns 0x5A.
- Response back-pressure: hold resp_busy=1 for 10 cycles during a read.
  - resp_send stays 0 and resp_packet is stable.
  - resp_send pulses exactly once in the cycle resp_busy falls.
- Illegal packet: post a bus_read_response packet as a request.
  - req_accept pulses once, proto_err_count=1, no resp_send, array unchanged.
- Reset mid-operation: assert reset during WAIT of a read.
  - Outputs go to 0 the next cycle and no response is ever sent.
  - A following read of a previously written address returns the old data.
- Counter saturation, CNT_WIDTH=4: issue 17 writes.
  - write_count=15.

Source files
------------

// File: rtl/bus_memory_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_memory_target_pkg
// Description : Shared memory-bus types and the target FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_memory_target_pkg;

    typedef logic [31:0] memory_address_t;
    typedef logic [63:0] bus_packet_payload_t;

    typedef enum logic [1:0] {
        bus_id_0 = 2'd0,
        bus_id_1 = 2'd1,
        bus_id_2 = 2'd2,
        bus_id_3 = 2'd3
    } BusID;

    typedef enum logic [1:0] {
        bus_read_data     = 2'd0,
        bus_write_data    = 2'd1,
        bus_read_response = 2'd2
    } bus_packet_type_t;

    typedef struct packed {
        bus_packet_type_t    packet_type;
        BusID                source;
        memory_address_t     address;
        bus_packet_payload_t payload;
    } BusPacket;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } target_state_t;

    function automatic logic is_request(input bus_packet_type_t t);
        return (t == bus_read_data) || (t == bus_write_data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/target_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : target_word_ram
// Description : Single-port synchronous word RAM, read data registered.
// Revision    : 1.0 - initial release
// ============================================================================
module target_word_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read register only updates on a read access, so it holds the last word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bus_memory_target.sv
`default_nettype none
// ============================================================================
// Module      : bus_memory_target
// Description : Memory-side bus endpoint: latency-delayed reads/writes, responses.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_memory_target
    import bus_memory_target_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  BusPacket             req_packet,
    output logic                 req_accept,
    input  logic                 resp_busy,
    output BusPacket             resp_packet,
    output logic                 resp_send,
    output logic [CNT_WIDTH-1:0] read_count,
    output logic [CNT_WIDTH-1:0] write_count,
    output logic [CNT_WIDTH-1:0] proto_err_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    target_state_t        r_state, w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    bus_packet_type_t     r_type;
    BusID                 r_src;
    logic [c_ADDR_W-1:0]  r_idx;
    bus_packet_payload_t  r_wdata;
    bus_packet_payload_t  w_rdata;
    logic                 r_req_accept;
    logic [CNT_WIDTH-1:0] r_rd_cnt, r_wr_cnt, r_err_cnt;
    logic                 w_capture, w_legal, w_access, w_is_write, w_ram_en;
    logic                 w_unused_addr;

    assign w_unused_addr = &{1'b0, req_packet.address[31:c_ADDR_W]};

    always_comb begin
        // A packet still on the bus during its accept cycle is the one just taken.
        w_capture    = (r_state == ST_IDLE) && req_valid && !r_req_accept;
        w_legal      = is_request(req_packet.packet_type);
        w_access     = (r_state == ST_WAIT) && (r_cnt == '0);
        w_is_write   = (r_type == bus_write_data);
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_capture && w_legal) w_next_state = ST_WAIT;
            ST_WAIT:    if (w_access) w_next_state = w_is_write ? ST_IDLE : ST_RESPOND;
            ST_RESPOND: if (!resp_busy) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_type       <= bus_read_data;
            r_src        <= bus_id_0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_req_accept <= 1'b0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_req_accept <= w_capture;
            if (w_capture) begin
                r_type  <= req_packet.packet_type;
                r_src   <= req_packet.source;
                r_idx   <= req_packet.address[c_ADDR_W-1:0];
                r_wdata <= req_packet.payload;
                r_cnt   <= c_CNT_W'(LATENCY - 1);
                if (!w_legal && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_access) begin
                if (w_is_write) begin
                    if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
                end else begin
                    if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Gate with reset so an access edge coinciding with reset never writes.
    assign w_ram_en = w_access && !reset;

    target_word_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  ($bits(bus_packet_payload_t)),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_is_write),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        resp_packet = '0;
        if (r_state == ST_RESPOND) begin
            resp_packet.packet_type = bus_read_response;
            resp_packet.source      = r_src;
            resp_packet.address     = '0;
            resp_packet.payload     = w_rdata;
        end
    end

    assign resp_send       = (r_state == ST_RESPOND) && !resp_busy;
    assign req_accept      = r_req_accept;
    assign read_count      = r_rd_cnt;
    assign write_count     = r_wr_cnt;
    assign proto_err_count = r_err_cnt;

    a_accept_needs_valid: assert property (@(posedge clk) disable iff (reset)
        req_accept |-> $past(req_valid));
    a_no_send_when_busy: assert property (@(posedge clk)
        !(resp_send && resp_busy));

endmodule
`default_nettype wire

// File: tb/tb_bus_memory_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_memory_target
// Description : Vector table plus scoreboard bench for bus_memory_target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_memory_target;
    import bus_memory_target_pkg::*;

    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            resp_busy = 1'b0;
    BusPacket        req_packet = '0;
    BusPacket        resp_packet;
    logic            req_accept, resp_send;
    logic [c_CW-1:0] read_count, write_count, proto_err_count;

    bus_memory_target #(.DEPTH(1024), .LATENCY(2), .CNT_WIDTH(c_CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_packet      (req_packet),
        .req_accept      (req_accept),
        .resp_busy       (resp_busy),
        .resp_packet     (resp_packet),
        .resp_send       (resp_send),
        .read_count      (read_count),
        .write_count     (write_count),
        .proto_err_count (proto_err_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, acc_cnt = 0, send_cnt = 0;
    int exp_acc = 0, exp_send = 0, exp_rd = 0, exp_wr = 0, exp_err = 0;

    typedef struct {
        BusPacket pkt;
        int       post_cyc;
        bit       chk_lat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bus_packet_type_t    ptype;
        BusID                src;
        memory_address_t     addr;
        bus_packet_payload_t data;
        bus_packet_payload_t exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic check_pkt(input string name, input BusPacket act, input BusPacket exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << c_CW) - 1) ? v : v + 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        sb_t e;
        if (req_accept) acc_cnt++;
        if (resp_send) begin
            send_cnt++;
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_pkt("resp_packet", resp_packet, e.pkt);
                if (e.chk_lat) check("resp_latency", 64'(cyc - e.post_cyc), 64'd3);
            end
        end
    end

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic post(input BusPacket p, input bus_packet_payload_t exp_data, input bit chk_lat);
        int  k = 0;
        sb_t e;
        drain();
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_packet = p;
        exp_acc++;
        if (p.packet_type == bus_read_data) begin
            e.pkt      = '{bus_read_response, p.source, 32'h0, exp_data};
            e.post_cyc = cyc;
            e.chk_lat  = chk_lat;
            sb_q.push_back(e);
            exp_send++;
            exp_rd = sat(exp_rd);
        end else if (p.packet_type == bus_write_data) begin
            exp_wr = sat(exp_wr);
        end else begin
            exp_err = sat(exp_err);
        end
        do begin
            @(posedge clk); #1;
            k++;
        end while (!req_accept && k < 20);
        check("accept_seen", 64'(req_accept), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_accepts"}, 64'(acc_cnt), 64'(exp_acc));
        check({tag, "_read_count"}, 64'(read_count), 64'(exp_rd));
        check({tag, "_write_count"}, 64'(write_count), 64'(exp_wr));
        check({tag, "_proto_err"}, 64'(proto_err_count), 64'(exp_err));
        check({tag, "_sends"}, 64'(send_cnt), 64'(exp_send));
    endtask

    // Reset lands on the access edge (cnt==0), the last chance to abort.
    task automatic abort_req(input BusPacket p);
        drain();
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_packet = p;
        @(posedge clk); #1;
        check("abort_accept", 64'(req_accept), 64'd1);
        exp_acc++;
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_outputs", 64'({req_accept, resp_send, read_count, write_count, proto_err_count}), 64'd0);
        check_pkt("abort_resp_packet", resp_packet, '0);
        reset   = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        exp_err = 0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_resp", 64'(send_cnt), 64'(exp_send));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        BusPacket p, bp_pkt;
        int bad;

        vecs[0] = '{bus_write_data,    bus_id_1, 32'h0000_0010, 64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[1] = '{bus_read_data,     bus_id_1, 32'h0000_0010, 64'h0, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{bus_write_data,    bus_id_2, 32'h0000_0400, 64'h5A, 64'h0};
        vecs[3] = '{bus_read_data,     bus_id_3, 32'h0000_0000, 64'h0, 64'h5A};
        vecs[4] = '{bus_write_data,    bus_id_0, 32'h0000_03FF, 64'h1111_2222_3333_4444, 64'h0};
        vecs[5] = '{bus_read_data,     bus_id_2, 32'hFFFF_FFFF, 64'h0, 64'h1111_2222_3333_4444};
        vecs[6] = '{bus_read_response, bus_id_1, 32'h0000_0010, 64'h999, 64'h0};
        vecs[7] = '{bus_read_data,     bus_id_1, 32'h0000_0010, 64'h0, 64'hDEADBEEF_CAFEF00D};
        vecs[8] = '{bus_write_data,    bus_id_1, 32'h0000_0010, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[9] = '{bus_read_data,     bus_id_0, 32'h0000_0410, 64'h0, 64'h0123_4567_89AB_CDEF};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({req_accept, resp_send, read_count, write_count, proto_err_count}), 64'd0);
        check_pkt("reset_resp_packet", resp_packet, '0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            p = '{vecs[i].ptype, vecs[i].src, vecs[i].addr, vecs[i].data};
            post(p, vecs[i].exp, 1'b1);
            drain();
            repeat (2) @(posedge clk);
            #1;
            check_counters($sformatf("vec%0d", i));
        end

        // Back-pressure: response slot busy before and during the read.
        resp_busy = 1'b1;
        post('{bus_read_data, bus_id_2, 32'h10, 64'h0}, 64'h0123_4567_89AB_CDEF, 1'b0);
        bp_pkt = '{bus_read_response, bus_id_2, 32'h0, 64'h0123_4567_89AB_CDEF};
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_send !== 1'b0 || resp_packet !== bp_pkt) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        check("bp_no_send", 64'(send_cnt), 64'(exp_send - 1));
        @(posedge clk); #1;
        resp_busy = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_counters("bp");

        abort_req('{bus_write_data, bus_id_1, 32'h10, 64'hBAD0_BAD0_BAD0_BAD0});
        abort_req('{bus_read_data, bus_id_1, 32'h10, 64'h0});
        post('{bus_read_data, bus_id_3, 32'h10, 64'h0}, 64'h0123_4567_89AB_CDEF, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_counters("post_abort");

        for (int i = 0; i < 17; i++) begin
            post('{bus_write_data, bus_id_0, 32'(i * 8), 64'(i + 100)}, 64'h0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("sat_write_count", 64'(write_count), 64'd15);
        post('{bus_read_data, bus_id_1, 32'h8, 64'h0}, 64'd101, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_counters("sat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
